// File: rtl/ldtu_dec_pkg.sv
// Shared constants and types for the LiTe-DTU stream decoder.
// Prefixes are listed MSB-first as they appear at the top of each 32-bit word.
package ldtu_dec_pkg;

  localparam logic [1:0] PFX_BAS  = 2'b01;
  localparam logic [5:0] PFX_SIG2 = 6'b001010;
  localparam logic [5:0] PFX_SIG1 = 6'b001011;
  localparam logic [3:0] PFX_HDR  = 4'b1101;
  localparam logic [3:0] PFX_IDLE = 4'b1110;

  localparam int BAS_W = 6;
  localparam int SIG_W = 13;

  localparam logic [2:0] BAS_LAST  = 3'd4;
  localparam logic [2:0] SIG2_LAST = 3'd1;
  localparam logic [2:0] SIG1_LAST = 3'd0;

  typedef enum logic [2:0] {
    W_BAS,
    W_SIG2,
    W_SIG1,
    W_HDR,
    W_IDLE,
    W_INV
  } word_class_t;

  typedef enum logic [1:0] {
    EMPTY,
    BAS,
    SIG
  } dec_state_t;

endpackage

// File: rtl/ldtu_word_classifier.sv
// Combinational word classifier: maps the top six bits of an encoded word to its class.
// Only the prefix bits are needed, so only those are brought in.
module ldtu_word_classifier
  import ldtu_dec_pkg::*;
(
  input  logic [5:0]  i_prefix,
  output word_class_t o_class
);

  // Baseline is checked first because its 2-bit prefix shadows nothing else.
  always_comb begin
    o_class = W_INV;
    if (i_prefix[5:4] == PFX_BAS) begin
      o_class = W_BAS;
    end else if (i_prefix == PFX_SIG2) begin
      o_class = W_SIG2;
    end else if (i_prefix == PFX_SIG1) begin
      o_class = W_SIG1;
    end else if (i_prefix[5:2] == PFX_HDR) begin
      o_class = W_HDR;
    end else if (i_prefix[5:2] == PFX_IDLE) begin
      o_class = W_IDLE;
    end
  end

endmodule

// File: rtl/ldtu_stream_decoder.sv
// LiTe-DTU stream decoder: unpacks baseline/signal words into one 13-bit sample per cycle,
// re-attaches the orbit (BC0) marker and counts invalid words.
module ldtu_stream_decoder
  import ldtu_dec_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [12:0]      out_sample,
  output logic             out_baseline,
  output logic             out_bc0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  dec_state_t       r_state;
  logic [29:0]      r_word;
  logic [2:0]       r_idx;
  logic [2:0]       r_last;
  logic             r_bc0Pending;
  logic             r_errPulse;
  logic [ERR_W-1:0] r_errCnt;

  word_class_t      w_class;
  logic             w_xfer;
  logic             w_lastXfer;
  logic             w_accept;
  logic [12:0]      w_sample;

  ldtu_word_classifier u_classifier (
    .i_prefix (in_data[31:26]),
    .o_class  (w_class)
  );

  assign out_valid  = (r_state != EMPTY);
  assign w_xfer     = out_valid & out_ready;
  assign w_lastXfer = w_xfer & (r_idx == r_last);
  // The last-sample transfer reopens the input so the next word loads without a bubble.
  assign in_ready   = ~rst & ((r_state == EMPTY) | w_lastXfer);
  assign w_accept   = in_valid & in_ready;

  always_comb begin
    w_sample = '0;
    case (r_state)
      BAS: begin
        case (r_idx)
          3'd0:    w_sample = {{(SIG_W-BAS_W){1'b0}}, r_word[5:0]};
          3'd1:    w_sample = {{(SIG_W-BAS_W){1'b0}}, r_word[11:6]};
          3'd2:    w_sample = {{(SIG_W-BAS_W){1'b0}}, r_word[17:12]};
          3'd3:    w_sample = {{(SIG_W-BAS_W){1'b0}}, r_word[23:18]};
          3'd4:    w_sample = {{(SIG_W-BAS_W){1'b0}}, r_word[29:24]};
          default: w_sample = '0;
        endcase
      end
      SIG: begin
        w_sample = (r_idx == 3'd0) ? r_word[12:0] : r_word[25:13];
      end
      default: w_sample = '0;
    endcase
  end

  assign out_sample   = w_sample;
  assign out_baseline = (r_state == BAS);
  assign out_bc0      = r_bc0Pending & out_valid;
  assign err_pulse    = r_errPulse;
  assign err_count    = r_errCnt;

  // A header accepted alongside a transfer sets the flag after the clear, so it lands on the next sample.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_word       <= '0;
      r_idx        <= '0;
      r_last       <= '0;
      r_bc0Pending <= 1'b0;
      r_errPulse   <= 1'b0;
      r_errCnt     <= '0;
    end else begin
      r_errPulse <= 1'b0;

      if (w_xfer) begin
        r_idx        <= r_idx + 3'd1;
        r_bc0Pending <= 1'b0;
      end
      if (w_lastXfer) begin
        r_state <= EMPTY;
      end

      if (w_accept) begin
        case (w_class)
          W_BAS: begin
            r_state <= BAS;
            r_word  <= in_data[29:0];
            r_idx   <= '0;
            r_last  <= BAS_LAST;
          end
          W_SIG2: begin
            r_state <= SIG;
            r_word  <= in_data[29:0];
            r_idx   <= '0;
            r_last  <= SIG2_LAST;
          end
          W_SIG1: begin
            r_state <= SIG;
            r_word  <= in_data[29:0];
            r_idx   <= '0;
            r_last  <= SIG1_LAST;
          end
          W_HDR: begin
            r_bc0Pending <= 1'b1;
          end
          W_IDLE: begin
          end
          default: begin
            r_errPulse <= 1'b1;
            if (r_errCnt != '1) begin
              r_errCnt <= r_errCnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ldtu_stream_decoder.md
# ldtu_stream_decoder

Back-end decoder for the LiTe-DTU compressed output stream. It accepts 32-bit words produced by the on-chip encoder: baseline words, signal words, orbit headers and idle words. It unpacks each data word into a stream of one 13-bit sample per cycle and re-attaches the orbit (BC0) marker to the first sample that follows a header. It sits in the test-bench and back-end firmware path, between the link word aligner and the sample FIFO.

## Interface
Parameters:
- ERR_W, 8, width of the saturating invalid-word counter.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  encoded word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  decoder accepts in_data this cycle.
- out_sample  out  13  decoded sample: bit 12 is the gain flag, bits 11:0 are the ADC value.
- out_baseline  out  1  sample came from a baseline word.
- out_bc0  out  1  first sample after an orbit header.
- out_valid  out  1  output fields are valid.
- out_ready  in  1  downstream accepts the sample.
- err_pulse  out  1  one-cycle pulse when an invalid word is dropped.
- err_count  out  ERR_W  count of invalid words; saturates at all-ones.

## Operation
Word classes (prefix is MSB-first; sample 0 sits at the LSBs):
- [31:30]=01: baseline word, 5×6-bit samples at [5:0], [11:6], [17:12], [23:18], [29:24]. Each sample is emitted zero-extended to 13 bits, so gain=0.
- [31:26]=001010: signal word, 2×13-bit samples at [12:0] and [25:13].
- [31:26]=001011: signal word, 1×13-bit sample at [12:0].
- [31:28]=1101: orbit header. Emits no sample; sets bc0_pending.
- [31:28]=1110: idle word. Dropped silently.
- Any other value is invalid: the word is dropped, err_pulse is asserted and err_count increments (saturating).

Serializer FSM, with a 32-bit word register and a 3-bit sample index idx:
- EMPTY: in_ready=1. A data word moves the FSM to BAS (idx=0) or SIG (idx=0, with last index 1 or 0). Header, idle and invalid words are consumed without leaving EMPTY.
- BAS: out_valid=1 and out_sample=field[idx]. On each transfer (out_valid&out_ready), idx increments. The transfer at idx=4 is the last sample.
- SIG: same as BAS, with last index 1 for a two-sample word and 0 for a one-sample word.
- On the last-sample transfer, in_ready=1 combinationally. A word accepted in that cycle loads directly, giving back-to-back output with no bubble. If no word is accepted, the FSM returns to EMPTY.
- In BAS/SIG before the last transfer, in_ready=0.
- bc0_pending is set when a header is accepted and cleared on the first sample transfer that follows. out_bc0 = bc0_pending while that sample is presented.
- Two headers with no sample between them leave a single pending flag and produce no error.
- A header accepted in the same cycle as the last-sample transfer applies to the next emitted sample, not the current one.

## Timing
- Reset state: FSM=EMPTY, idx=0, bc0_pending=0, err_count=0. All outputs are 0 except in_ready, which is 0 during reset and 1 in the first cycle after reset.
- A data word accepted in cycle N presents sample 0 in cycle N+1.
- Latency from input to first sample is 1 cycle. Throughput is 1 sample per cycle while out_ready=1.
- A header or idle word costs one input cycle and adds no output cycle.
- Holding rule: with out_valid=1 and out_ready=0, all out_* fields hold stable.
- Holding rule: in_valid with in_ready=0 holds no state in the decoder; the upstream side must hold its word.
- err_pulse is asserted in cycle N+1 for an invalid word accepted in cycle N. err_count updates in that same cycle.
- Reset mid-word discards the remaining samples and any pending BC0. No partial output appears after reset.

## Structure
- Shared package ldtu_dec_pkg holds:
  - prefix constants PFX_BAS=2'b01, PFX_SIG2=6'b001010, PFX_SIG1=6'b001011, PFX_HDR=4'b1101, PFX_IDLE=4'b1110;
  - sample widths: BAS_W=6, SIG_W=13;
  - the word-class enum {W_BAS, W_SIG2, W_SIG1, W_HDR, W_IDLE, W_INV};
  - the FSM state enum {EMPTY, BAS, SIG}.
- One combinational sub-module, ldtu_word_classifier, maps in_data to a word class. The top level holds the FSM, the serializer, the BC0 logic and the error counter.

## Test plan
- Baseline unpack: 0x45103081 with out_ready=1 → samples 1, 2, 3, 4, 5 on 5 consecutive cycles, each with out_baseline=1 and out_bc0=0.
- Signal unpack, back-to-back: 0x28247ABC, then 0x2C000FFF presented on the cycle of the last transfer → 0x1ABC, 0x0123, 0x0FFF on consecutive cycles with no bubble and out_baseline=0.
- Orbit marking: 0xD0000000, then 0xE0000000, then 0x45103081 → out_bc0=1 only on sample 1; two headers in a row still give a single out_bc0.
- Invalid words: 0x00000000 and 0x30000000 → no output, two err_pulse cycles, err_count=2. Forcing 300 invalid words → err_count=255.
- Backpressure: out_ready=0 for 3 cycles during sample 2 of 0x45103081 → sample 2 held stable, in_ready=0, and the full sequence 1..5 is delivered intact.
- Mid-word reset: rst pulsed after sample 1 of 0x45103081, with a header pending → out_valid=0, err_count=0, and the next word decodes cleanly with out_bc0=0.
